// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl (with helper full_adder)
// Brief    : Bit-serial adder, one full_adder reused LSB-first over WIDTH
//            cycles. Define SERIAL_ADD_SUB_EN to add the 'sub' port (a - b).
// Revision : 1.0 - initial release
// ============================================================================

module full_adder (
    input  logic A,
    input  logic B,
    input  logic C,
    output logic sum,
    output logic cout
);
    assign sum  = A ^ B ^ C;
    assign cout = (A & B) | (A & C) | (B & C);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int            CW     = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;
    logic             w_fa_sum;
    logic             w_fa_cout;

    // Subtraction is folded into the capture: a + ~b + 1 runs through the same adder.
`ifdef SERIAL_ADD_SUB_EN
    assign w_b_load = sub ? ~b : b;
    assign w_c_load = sub ? 1'b1 : cin;
`else
    assign w_b_load = b;
    assign w_c_load = cin;
`endif

    full_adder u_fa (
        .A    (r_a_sr[0]),
        .B    (r_b_sr[0]),
        .C    (r_carry),
        .sum  (w_fa_sum),
        .cout (w_fa_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sr  <= a;
                        r_b_sr  <= w_b_load;
                        r_carry <= w_c_load;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a_sr  <= r_a_sr >> 1;
                    r_b_sr  <= r_b_sr >> 1;
                    r_sum   <= {w_fa_sum, r_sum[WIDTH-1:1]};
                    r_carry <= w_fa_cout;
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == c_LAST) begin
                        r_cout  <= w_fa_cout;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Registered pulse lands the cycle after DONE, keeping it clear of busy.
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
`default_nettype wire

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, operand and result width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  operand A; captured on the accepted start.
REQ-006 Port: b  input  WIDTH  operand B; captured on the accepted start.
REQ-007 Port: cin  input  1  carry-in; captured on the accepted start.
REQ-008 Port: busy  output  1  high while an operation is in progress (RUN state).
REQ-009 Port: done  output  1  one-cycle pulse when the result becomes valid.
REQ-010 Port: sum  output  WIDTH  result; valid from the done cycle until the next accepted start.
REQ-011 Port: cout  output  1  final carry-out; same validity as sum.
REQ-012 The block has one clock, clk; reset rst is synchronous and active-high.

Function
REQ-013 The block instantiates exactly one full_adder (ports A, B, C, sum, cout) and uses it for every bit of the add, one bit per cycle, LSB first.
REQ-014 FSM states: IDLE, RUN, DONE.
REQ-015 IDLE with start=1: capture a, b and cin into the operand shift registers and carry register; clear the bit counter; next state RUN.
REQ-016 IDLE with start=0: remain in IDLE; sum and cout hold their values.
REQ-017 RUN, each cycle: drive full_adder A/B from the operand LSBs and C from the carry register; shift the adder sum into the result MSB (result shifts right); load the carry register from the adder cout; increment the counter.
REQ-018 RUN ends after exactly WIDTH bit-cycles; next state DONE; cout takes the carry from the final bit.
REQ-019 DONE: done=1 for exactly one cycle; next state IDLE unconditionally.
REQ-020 start is ignored in RUN and DONE; captured operands are not disturbed.
REQ-021 Latency: start accepted at edge N gives done=1 in the cycle after edge N+WIDTH+1 (WIDTH+1 cycles from acceptance to the done pulse).
REQ-022 busy=1 only in RUN; busy and done are never high together.
REQ-023 sum and cout change only during RUN; they are stable throughout IDLE and DONE.
REQ-024 Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.

Reset
REQ-025 On rst=1 at a clock edge: state goes to IDLE, and busy=0, done=0, sum=0, cout=0, counter=0, carry register=0.
REQ-026 rst overrides start and any operation in progress; a partial result is discarded and no done pulse is produced.
REQ-027 After rst is released, the first start is accepted normally.

Configuration
REQ-028 Macro SERIAL_ADD_SUB_EN: when defined, adds port sub (input, 1), which is captured with the operands on start.
REQ-029 With SERIAL_ADD_SUB_EN defined and sub=1: compute a - b as a + ~b + 1 (cin ignored); cout=1 means no borrow.
REQ-030 With SERIAL_ADD_SUB_EN defined and sub=0, behaviour is identical to REQ-024.
REQ-031 Without SERIAL_ADD_SUB_EN: the sub port is absent and the block is add-only, per REQ-024.

Verification (WIDTH=8)
REQ-032 Apply a=8'h00, b=8'h00, cin=0, start pulse -> busy for 8 cycles, done after 9 cycles, sum=8'h00, cout=0.
REQ-033 Apply a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; apply a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1.
REQ-034 Apply a=8'h3C, b=8'h0F, then pulse start with a=8'hFF, b=8'hFF during RUN -> result sum=8'h4B, cout=0; second start ignored, single done pulse.
REQ-035 Assert rst in the 4th RUN cycle of a=8'hFF, b=8'h01 -> next cycle busy=0, sum=8'h00, cout=0, no done pulse; a following start with a=8'h02, b=8'h03 -> sum=8'h05.
REQ-036 With SERIAL_ADD_SUB_EN: a=8'h05, b=8'h07, sub=1 -> sum=8'hFE, cout=0; a=8'h07, b=8'h05, sub=1 -> sum=8'h02, cout=1.
REQ-037 Random sweep of 1000 operand/cin triples checked against a + b + cin, with done asserted exactly once per accepted start.
